player_move_ctrl: RTL and testbench

- Game-logic controller that steps the player one map cell per move period, using the wall map to block moves.
- On each frame tick it samples the direction buttons, computes a target cell, and requests a read of the shared map ROM through a req/gnt handshake with the ROM arbiter.
- It checks the wall bit and then commits or rejects the move.
- Its outputs drive player_x_pos/player_y_pos of the VGA renderer.

---
 rtl/player_move_ctrl.sv | 152 +++++++++++++++
 tb/tb_player_move_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// Player movement controller: steps one map cell per MOVE_DIV frame ticks, wall-checked via the shared map ROM.
// Optional build macro PLAYER_WRAP_EN makes out-of-range targets wrap toroidally instead of blocking.
module player_move_ctrl #(
    parameter int MAP_W    = 21,
    parameter int MAP_H    = 30,
    parameter int ADDRW    = 5,
    parameter int START_X  = 1,
    parameter int START_Y  = 1,
    parameter int MOVE_DIV = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic             rom_req,
    input  logic             rom_gnt,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [MAP_H-1:0] rom_data,
    output logic [7:0]       player_x_pos,
    output logic [7:0]       player_y_pos,
    output logic             moved,
    output logic             blocked,
    output logic             busy
);

    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int YW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam logic [CW-1:0]       CNT_LAST = CW'(MOVE_DIV - 1);
    localparam logic signed [8:0]   X_MAX    = 9'(MAP_W - 1);
    localparam logic signed [8:0]   Y_MAX    = 9'(MAP_H - 1);
`ifdef PLAYER_WRAP_EN
    localparam logic [7:0]          X_LAST   = 8'(MAP_W - 1);
    localparam logic [7:0]          Y_LAST   = 8'(MAP_H - 1);
`endif

    typedef enum logic [1:0] {IDLE, REQ, CHECK} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   frame_cnt, frame_cnt_n;
    logic [7:0]      tgt_x, tgt_x_n, tgt_y, tgt_y_n;
    logic [7:0]      x_n, y_n;
    logic            moved_n, blocked_n;
    logic signed [8:0] cand_x, cand_y;
    logic [7:0]      new_x, new_y;
    logic            any_btn;
`ifndef PLAYER_WRAP_EN
    logic            edge_hit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            tgt_x        <= '0;
            tgt_y        <= '0;
            player_x_pos <= 8'(START_X);
            player_y_pos <= 8'(START_Y);
            moved        <= 1'b0;
            blocked      <= 1'b0;
        end else begin
            state        <= state_n;
            frame_cnt    <= frame_cnt_n;
            tgt_x        <= tgt_x_n;
            tgt_y        <= tgt_y_n;
            player_x_pos <= x_n;
            player_y_pos <= y_n;
            moved        <= moved_n;
            blocked      <= blocked_n;
        end
    end

    // Target is held in tgt_x through REQ and CHECK, so the ROM address stays stable.
    assign rom_addr = tgt_x[ADDRW-1:0];
    assign rom_req  = (state == REQ);
    assign busy     = (state != IDLE);

    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        tgt_x_n     = tgt_x;
        tgt_y_n     = tgt_y;
        x_n         = player_x_pos;
        y_n         = player_y_pos;
        moved_n     = 1'b0;
        blocked_n   = 1'b0;

        cand_x  = $signed({1'b0, player_x_pos});
        cand_y  = $signed({1'b0, player_y_pos});
        any_btn = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)         cand_y = cand_y - 9'sd1;
        else if (btn_down)  cand_y = cand_y + 9'sd1;
        else if (btn_left)  cand_x = cand_x - 9'sd1;
        else if (btn_right) cand_x = cand_x + 9'sd1;

        new_x = cand_x[7:0];
        new_y = cand_y[7:0];
`ifdef PLAYER_WRAP_EN
        if (cand_x < 9'sd0)       new_x = X_LAST;
        else if (cand_x > X_MAX)  new_x = '0;
        if (cand_y < 9'sd0)       new_y = Y_LAST;
        else if (cand_y > Y_MAX)  new_y = '0;
`else
        edge_hit = (cand_x < 9'sd0) || (cand_x > X_MAX) ||
                   (cand_y < 9'sd0) || (cand_y > Y_MAX);
`endif

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt_n = '0;
                        if (any_btn) begin
`ifdef PLAYER_WRAP_EN
                            tgt_x_n = new_x;
                            tgt_y_n = new_y;
                            state_n = REQ;
`else
                            if (edge_hit) begin
                                blocked_n = 1'b1;
                            end else begin
                                tgt_x_n = new_x;
                                tgt_y_n = new_y;
                                state_n = REQ;
                            end
`endif
                        end
                    end else begin
                        frame_cnt_n = frame_cnt + CW'(1);
                    end
                end
            end
            REQ: begin
                if (rom_gnt) state_n = CHECK;
            end
            CHECK: begin
                if (rom_data[tgt_y[YW-1:0]]) begin
                    blocked_n = 1'b1;
                end else begin
                    x_n     = tgt_x;
                    y_n     = tgt_y;
                    moved_n = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: one instance with MOVE_DIV=1, one with MOVE_DIV=4, behavioural map ROM.
module tb_player_move_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        rom_req, rom_gnt = 1'b1;
    logic [4:0]  rom_addr;
    logic [29:0] rom_data = '0;
    logic [7:0]  x, y;
    logic        moved, blocked, busy;

    logic        tick4 = 1'b0, btn4_down = 1'b0, gnt4 = 1'b1;
    logic        req4, moved4, blocked4, busy4;
    logic [4:0]  addr4;
    logic [29:0] data4 = '0;
    logic [7:0]  x4, y4;

    logic [29:0] map_mem [0:31];

    int n_err = 0;
    int n_checks = 0;

`ifdef PLAYER_WRAP_EN
    localparam logic [7:0] EXP_X = 8'd0;
`else
    localparam logic [7:0] EXP_X = 8'd1;
`endif

    always #5 clk = ~clk;

    player_move_ctrl #(.MOVE_DIV(1)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .rom_req(rom_req), .rom_gnt(rom_gnt), .rom_addr(rom_addr), .rom_data(rom_data),
        .player_x_pos(x), .player_y_pos(y), .moved(moved), .blocked(blocked), .busy(busy)
    );

    player_move_ctrl #(.MOVE_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .frame_tick(tick4),
        .btn_up(1'b0), .btn_down(btn4_down), .btn_left(1'b0), .btn_right(1'b0),
        .rom_req(req4), .rom_gnt(gnt4), .rom_addr(addr4), .rom_data(data4),
        .player_x_pos(x4), .player_y_pos(y4), .moved(moved4), .blocked(blocked4), .busy(busy4)
    );

    // Registered ROM: word appears the cycle after a req&gnt cycle.
    always @(posedge clk) begin
        if (rom_req && rom_gnt) rom_data <= map_mem[rom_addr];
        if (req4 && gnt4)       data4    <= map_mem[addr4];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // b = {up, down, left, right}; wait_n = grant-low cycles in REQ (ticks injected meanwhile).
    task automatic run_move(input string tag, input logic [3:0] b, input int unsigned wait_n,
                            input bit exp_rom, input logic [4:0] exp_addr, input bit exp_move,
                            input logic [7:0] ex, input logic [7:0] ey);
        {btn_up, btn_down, btn_left, btn_right} = b;
        rom_gnt    = (wait_n == 0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        if (exp_rom) begin
            check({tag, " req"}, rom_req, 1);
            check({tag, " addr"}, rom_addr, exp_addr);
            check({tag, " no_moved_early"}, moved, 0);
            for (int unsigned i = 0; i < wait_n; i++) begin
                frame_tick = (i == 2 || i == 5);
                @(negedge clk);
                check({tag, " req_hold"}, rom_req, 1);
                check({tag, " addr_hold"}, rom_addr, exp_addr);
            end
            frame_tick = 1'b0;
            rom_gnt    = 1'b1;
            @(negedge clk);
            check({tag, " req_drop"}, rom_req, 0);
            check({tag, " busy_check"}, busy, 1);
            @(negedge clk);
            check({tag, " moved"}, moved, exp_move);
            check({tag, " blocked"}, blocked, !exp_move);
        end else begin
            check({tag, " no_req"}, rom_req, 0);
            check({tag, " blocked"}, blocked, 1);
            check({tag, " moved"}, moved, 0);
            check({tag, " busy"}, busy, 0);
        end
        check({tag, " x"}, x, ex);
        check({tag, " y"}, y, ey);
        @(negedge clk);
        check({tag, " moved_end"}, moved, 0);
        check({tag, " blocked_end"}, blocked, 0);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " req_end"}, rom_req, 0);
    endtask

    initial begin
        int unsigned n_moves4;
        for (int i = 0; i < 32; i++) map_mem[i] = '0;
        map_mem[1][0] = 1'b1;

        @(negedge clk);
        check("rst x", x, 1);
        check("rst y", y, 1);
        check("rst req", rom_req, 0);
        check("rst addr", rom_addr, 0);
        check("rst busy", busy, 0);
        check("rst moved", moved, 0);
        check("rst blocked", blocked, 0);
        reset = 1'b0;
        @(negedge clk);

        run_move("right", 4'b0001, 0, 1, 5'd2, 1, 8'd2, 8'd1);

        reset = 1'b1;
        @(negedge clk);
        check("rst2 x", x, 1);
        check("rst2 y", y, 1);
        reset = 1'b0;
        @(negedge clk);

        run_move("wall", 4'b1000, 0, 1, 5'd1, 0, 8'd1, 8'd1);
        run_move("stall", 4'b0100, 10, 1, 5'd1, 1, 8'd1, 8'd2);
        run_move("left", 4'b0010, 0, 1, 5'd0, 1, 8'd0, 8'd2);
        run_move("down3", 4'b0100, 0, 1, 5'd0, 1, 8'd0, 8'd3);
        run_move("down4", 4'b0100, 0, 1, 5'd0, 1, 8'd0, 8'd4);
        run_move("down5", 4'b0100, 0, 1, 5'd0, 1, 8'd0, 8'd5);
`ifdef PLAYER_WRAP_EN
        run_move("edge_left", 4'b0010, 0, 1, 5'd20, 1, 8'd20, 8'd5);
        run_move("edge_right", 4'b0001, 0, 1, 5'd0, 1, 8'd0, 8'd5);
`else
        run_move("edge_left", 4'b0010, 0, 0, 5'd0, 0, 8'd0, 8'd5);
        run_move("step_right", 4'b0001, 0, 1, 5'd1, 1, 8'd1, 8'd5);
`endif
        run_move("prio", 4'b1100, 0, 1, EXP_X[4:0], 1, EXP_X, 8'd4);

        n_moves4  = 0;
        btn4_down = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick4 = 1'b1;
            @(negedge clk);
            tick4 = 1'b0;
            if (moved4) n_moves4++;
            repeat (5) begin
                @(negedge clk);
                if (moved4) n_moves4++;
            end
            check($sformatf("div4 y tick%0d", i + 1), y4, 1 + (i + 1) / 4);
        end
        btn4_down = 1'b0;
        check("div4 moves", n_moves4, 3);
        check("div4 x", x4, 1);
        check("div4 blocked", blocked4, 0);

        btn_down   = 1'b1;
        rom_gnt    = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        btn_down   = 1'b0;
        check("areset pre req", rom_req, 1);
        #2 reset = 1'b1;
        #1;
        check("areset req", rom_req, 0);
        check("areset busy", busy, 0);
        check("areset x", x, 1);
        check("areset y", y, 1);
        check("areset y4", y4, 1);
        @(negedge clk);
        reset   = 1'b0;
        rom_gnt = 1'b1;
        @(negedge clk);
        check("areset idle busy", busy, 0);
        check("areset idle req", rom_req, 0);
        @(negedge clk);
        check("areset no commit", moved, 0);
        check("areset hold y", y, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
